// File: rtl/iddr_calib_pkg.sv
// Shared types and constants for the IDELAY training controller.
package iddr_calib_pkg;

  localparam int unsigned TAP_W      = 9;
  localparam int unsigned WIN_W      = 10;
  localparam int unsigned MIN_SETTLE = 4;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_VTC_OFF,
    S_LOAD0,
    S_SETTLE,
    S_SAMPLE,
    S_STEP,
    S_CENTER,
    S_FINAL_SETTLE,
    S_DONE,
    S_FAIL
  } state_t;

endpackage

// File: rtl/iddr_calib_window.sv
// Tracks the current run of passing taps and remembers the longest one.
// The earliest window wins ties because replacement needs a strictly longer run.
module iddr_calib_window
  import iddr_calib_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             pass,
  input  logic             miss,
  input  logic [TAP_W-1:0] tap,
  output logic [TAP_W-1:0] best_start,
  output logic [WIN_W-1:0] best_len
);

  logic [TAP_W-1:0] cur_start;
  logic [WIN_W-1:0] cur_len;
  logic [TAP_W-1:0] run_start_c;
  logic [WIN_W-1:0] run_len_c;

  // Candidate run if the current tap passes.
  always_comb begin
    run_start_c = (cur_len == '0) ? tap : cur_start;
    run_len_c   = cur_len + WIN_W'(1);
  end

  // Run and best-window registers.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (pass) begin
      cur_start <= run_start_c;
      cur_len   <= run_len_c;
      if (run_len_c > best_len) begin
        best_start <= run_start_c;
        best_len   <= run_len_c;
      end
    end else if (miss) begin
      cur_len <= '0;
    end
  end

endmodule

// File: rtl/iddr_delay_calib.sv
// Training controller for the IDELAYE3 iddr stage: sweeps the shared tap,
// finds the longest passing window for the training pattern and loads its centre.
// Optional tap readback check: define IDDR_CALIB_READBACK_EN.
module iddr_delay_calib
  import iddr_calib_pkg::*;
#(
  parameter int unsigned      WIDTH         = 1,
  parameter logic [WIDTH-1:0] PAT_Q1        = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] PAT_Q2        = {WIDTH{1'b0}},
  parameter int unsigned      MAX_TAP       = 511,
  parameter int unsigned      SETTLE_CYCLES = 8,
  parameter int unsigned      SAMPLE_CYCLES = 16,
  parameter int unsigned      DEFAULT_TAP   = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       q1,
  input  logic [WIDTH-1:0]       q2,
  input  logic [WIDTH*TAP_W-1:0] cnt_value_out,
  output logic                   delay_en,
  output logic                   delay_inc,
  output logic                   delay_load,
  output logic [TAP_W-1:0]       delay_cnt_value,
  output logic                   delay_en_vtc,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [TAP_W-1:0]       tap_center,
  output logic [WIN_W-1:0]       window_len
`ifdef IDDR_CALIB_READBACK_EN
  ,
  output logic                   readback_err
`endif
);

  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES < MIN_SETTLE) ? MIN_SETTLE : SETTLE_CYCLES;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [TAP_W-1:0] tap;
  logic [TAP_W-1:0] tap_next;
  logic [1:0]       inc_hold;
  logic [1:0]       inc_hold_next;
  logic             final_fail;
  logic             final_fail_next;

  logic             en_next;
  logic             inc_next;
  logic             load_next;
  logic [TAP_W-1:0] cnt_value_next;
  logic             vtc_next;
  logic             busy_next;
  logic             done_next;
  logic             fail_next;
  logic [TAP_W-1:0] center_next;
  logic [WIN_W-1:0] len_next;
`ifdef IDDR_CALIB_READBACK_EN
  logic             readback_err_next;
`endif

  logic             match_c;
  logic             settle_end_c;
  logic             sample_end_c;
  logic             pass_c;
  logic             miss_c;
  logic             rb_bad_c;
  logic [TAP_W-1:0] best_start;
  logic [WIN_W-1:0] best_len;
  logic [TAP_W-1:0] center_c;

  // All lanes must show the training pattern on both edges.
  always_comb begin
    match_c      = (q1 == PAT_Q1) && (q2 == PAT_Q2);
    settle_end_c = (cnt == CNT_W'(SETTLE_EFF - 1));
    sample_end_c = (cnt == CNT_W'(SAMPLE_CYCLES - 1));
    pass_c       = (state == S_SAMPLE) && match_c && sample_end_c;
    miss_c       = (state == S_SAMPLE) && !match_c;
    center_c     = TAP_W'(WIN_W'(best_start) + (best_len >> 1));
  end

`ifdef IDDR_CALIB_READBACK_EN
  // Every lane's tap readback must agree with the commanded tap.
  always_comb begin
    rb_bad_c = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (cnt_value_out[i*TAP_W +: TAP_W] != tap) rb_bad_c = 1'b1;
    end
  end
`else
  logic unused_readback;
  assign unused_readback = ^cnt_value_out;
  assign rb_bad_c        = 1'b0;
`endif

  iddr_calib_window u_window (
    .clk        (clk),
    .rst        (rst),
    .clr        (state == S_LOAD0),
    .pass       (pass_c),
    .miss       (miss_c),
    .tap        (tap),
    .best_start (best_start),
    .best_len   (best_len)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE, S_FAIL: if (start) state_next = S_VTC_OFF;
      S_VTC_OFF:              if (cnt == CNT_W'(1)) state_next = S_LOAD0;
      S_LOAD0:                state_next = S_SETTLE;
      S_SETTLE:               if (settle_end_c) state_next = rb_bad_c ? S_FAIL : S_SAMPLE;
      S_SAMPLE: begin
        if (!match_c || sample_end_c)
          state_next = (tap == TAP_W'(MAX_TAP)) ? S_CENTER : S_STEP;
      end
      S_STEP:                 state_next = S_SETTLE;
      S_CENTER:               state_next = S_FINAL_SETTLE;
      S_FINAL_SETTLE:         if (settle_end_c) state_next = final_fail ? S_FAIL : S_DONE;
      default:                state_next = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath.
  always_comb begin
    en_next         = 1'b0;
    load_next       = 1'b0;
    inc_next        = (inc_hold != 2'd0);
    inc_hold_next   = (inc_hold != 2'd0) ? inc_hold - 2'd1 : 2'd0;
    cnt_value_next  = delay_cnt_value;
    vtc_next        = delay_en_vtc;
    busy_next       = busy;
    done_next       = done;
    fail_next       = fail;
    center_next     = tap_center;
    len_next        = window_len;
    tap_next        = tap;
    final_fail_next = final_fail;
    cnt_next        = (state_next != state) ? '0 : cnt + CNT_W'(1);
`ifdef IDDR_CALIB_READBACK_EN
    readback_err_next = readback_err;
`endif
    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          done_next = 1'b0;
          fail_next = 1'b0;
          busy_next = 1'b1;
          vtc_next  = 1'b0;
`ifdef IDDR_CALIB_READBACK_EN
          readback_err_next = 1'b0;
`endif
        end
      end
      S_LOAD0: begin
        load_next      = 1'b1;
        cnt_value_next = '0;
        tap_next       = '0;
      end
      S_SETTLE: begin
        if (settle_end_c && rb_bad_c) begin
          load_next      = 1'b1;
          cnt_value_next = TAP_W'(DEFAULT_TAP);
          center_next    = TAP_W'(DEFAULT_TAP);
          len_next       = '0;
          vtc_next       = 1'b1;
          busy_next      = 1'b0;
          fail_next      = 1'b1;
`ifdef IDDR_CALIB_READBACK_EN
          readback_err_next = 1'b1;
`endif
        end
      end
      S_STEP: begin
        en_next       = 1'b1;
        inc_next      = 1'b1;
        inc_hold_next = 2'd3;
        tap_next      = tap + TAP_W'(1);
      end
      S_CENTER: begin
        load_next       = 1'b1;
        final_fail_next = (best_len == '0);
        len_next        = best_len;
        if (best_len == '0) begin
          cnt_value_next = TAP_W'(DEFAULT_TAP);
          center_next    = TAP_W'(DEFAULT_TAP);
        end else begin
          cnt_value_next = center_c;
          center_next    = center_c;
        end
      end
      S_FINAL_SETTLE: begin
        if (settle_end_c) begin
          vtc_next  = 1'b1;
          busy_next = 1'b0;
          if (final_fail) fail_next = 1'b1;
          else            done_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers; reset aborts with no pending pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      tap             <= '0;
      inc_hold        <= 2'd0;
      final_fail      <= 1'b0;
      delay_en        <= 1'b0;
      delay_inc       <= 1'b0;
      delay_load      <= 1'b0;
      delay_cnt_value <= '0;
      delay_en_vtc    <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      fail            <= 1'b0;
      tap_center      <= '0;
      window_len      <= '0;
`ifdef IDDR_CALIB_READBACK_EN
      readback_err    <= 1'b0;
`endif
    end else begin
      cnt             <= cnt_next;
      tap             <= tap_next;
      inc_hold        <= inc_hold_next;
      final_fail      <= final_fail_next;
      delay_en        <= en_next;
      delay_inc       <= inc_next;
      delay_load      <= load_next;
      delay_cnt_value <= cnt_value_next;
      delay_en_vtc    <= vtc_next;
      busy            <= busy_next;
      done            <= done_next;
      fail            <= fail_next;
      tap_center      <= center_next;
      window_len      <= len_next;
`ifdef IDDR_CALIB_READBACK_EN
      readback_err    <= readback_err_next;
`endif
    end
  end

endmodule
